// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key schedule, round counter and datapath.
//   AES_NR    : last round index for AES-128
//   RCON_INIT : round constant applied when deriving round key 1
//   word32_t  : one 32-bit schedule word, big-endian bytes
//   xtime()   : multiply by x (i.e. 2) in GF(2^8) mod x^8+x^4+x^3+x+1
package aes_pkg;

   localparam int         AES_NR    = 10;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef logic [31:0] word32_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, pure combinational lookup.
//   a   : input byte
//   sub : substituted byte
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] sub
);

   always_comb begin
      sub = 8'h00;
      case (a)
         8'h00: sub = 8'h63; 8'h01: sub = 8'h7c; 8'h02: sub = 8'h77; 8'h03: sub = 8'h7b; 8'h04: sub = 8'hf2; 8'h05: sub = 8'h6b; 8'h06: sub = 8'h6f; 8'h07: sub = 8'hc5;
         8'h08: sub = 8'h30; 8'h09: sub = 8'h01; 8'h0a: sub = 8'h67; 8'h0b: sub = 8'h2b; 8'h0c: sub = 8'hfe; 8'h0d: sub = 8'hd7; 8'h0e: sub = 8'hab; 8'h0f: sub = 8'h76;
         8'h10: sub = 8'hca; 8'h11: sub = 8'h82; 8'h12: sub = 8'hc9; 8'h13: sub = 8'h7d; 8'h14: sub = 8'hfa; 8'h15: sub = 8'h59; 8'h16: sub = 8'h47; 8'h17: sub = 8'hf0;
         8'h18: sub = 8'had; 8'h19: sub = 8'hd4; 8'h1a: sub = 8'ha2; 8'h1b: sub = 8'haf; 8'h1c: sub = 8'h9c; 8'h1d: sub = 8'ha4; 8'h1e: sub = 8'h72; 8'h1f: sub = 8'hc0;
         8'h20: sub = 8'hb7; 8'h21: sub = 8'hfd; 8'h22: sub = 8'h93; 8'h23: sub = 8'h26; 8'h24: sub = 8'h36; 8'h25: sub = 8'h3f; 8'h26: sub = 8'hf7; 8'h27: sub = 8'hcc;
         8'h28: sub = 8'h34; 8'h29: sub = 8'ha5; 8'h2a: sub = 8'he5; 8'h2b: sub = 8'hf1; 8'h2c: sub = 8'h71; 8'h2d: sub = 8'hd8; 8'h2e: sub = 8'h31; 8'h2f: sub = 8'h15;
         8'h30: sub = 8'h04; 8'h31: sub = 8'hc7; 8'h32: sub = 8'h23; 8'h33: sub = 8'hc3; 8'h34: sub = 8'h18; 8'h35: sub = 8'h96; 8'h36: sub = 8'h05; 8'h37: sub = 8'h9a;
         8'h38: sub = 8'h07; 8'h39: sub = 8'h12; 8'h3a: sub = 8'h80; 8'h3b: sub = 8'he2; 8'h3c: sub = 8'heb; 8'h3d: sub = 8'h27; 8'h3e: sub = 8'hb2; 8'h3f: sub = 8'h75;
         8'h40: sub = 8'h09; 8'h41: sub = 8'h83; 8'h42: sub = 8'h2c; 8'h43: sub = 8'h1a; 8'h44: sub = 8'h1b; 8'h45: sub = 8'h6e; 8'h46: sub = 8'h5a; 8'h47: sub = 8'ha0;
         8'h48: sub = 8'h52; 8'h49: sub = 8'h3b; 8'h4a: sub = 8'hd6; 8'h4b: sub = 8'hb3; 8'h4c: sub = 8'h29; 8'h4d: sub = 8'he3; 8'h4e: sub = 8'h2f; 8'h4f: sub = 8'h84;
         8'h50: sub = 8'h53; 8'h51: sub = 8'hd1; 8'h52: sub = 8'h00; 8'h53: sub = 8'hed; 8'h54: sub = 8'h20; 8'h55: sub = 8'hfc; 8'h56: sub = 8'hb1; 8'h57: sub = 8'h5b;
         8'h58: sub = 8'h6a; 8'h59: sub = 8'hcb; 8'h5a: sub = 8'hbe; 8'h5b: sub = 8'h39; 8'h5c: sub = 8'h4a; 8'h5d: sub = 8'h4c; 8'h5e: sub = 8'h58; 8'h5f: sub = 8'hcf;
         8'h60: sub = 8'hd0; 8'h61: sub = 8'hef; 8'h62: sub = 8'haa; 8'h63: sub = 8'hfb; 8'h64: sub = 8'h43; 8'h65: sub = 8'h4d; 8'h66: sub = 8'h33; 8'h67: sub = 8'h85;
         8'h68: sub = 8'h45; 8'h69: sub = 8'hf9; 8'h6a: sub = 8'h02; 8'h6b: sub = 8'h7f; 8'h6c: sub = 8'h50; 8'h6d: sub = 8'h3c; 8'h6e: sub = 8'h9f; 8'h6f: sub = 8'ha8;
         8'h70: sub = 8'h51; 8'h71: sub = 8'ha3; 8'h72: sub = 8'h40; 8'h73: sub = 8'h8f; 8'h74: sub = 8'h92; 8'h75: sub = 8'h9d; 8'h76: sub = 8'h38; 8'h77: sub = 8'hf5;
         8'h78: sub = 8'hbc; 8'h79: sub = 8'hb6; 8'h7a: sub = 8'hda; 8'h7b: sub = 8'h21; 8'h7c: sub = 8'h10; 8'h7d: sub = 8'hff; 8'h7e: sub = 8'hf3; 8'h7f: sub = 8'hd2;
         8'h80: sub = 8'hcd; 8'h81: sub = 8'h0c; 8'h82: sub = 8'h13; 8'h83: sub = 8'hec; 8'h84: sub = 8'h5f; 8'h85: sub = 8'h97; 8'h86: sub = 8'h44; 8'h87: sub = 8'h17;
         8'h88: sub = 8'hc4; 8'h89: sub = 8'ha7; 8'h8a: sub = 8'h7e; 8'h8b: sub = 8'h3d; 8'h8c: sub = 8'h64; 8'h8d: sub = 8'h5d; 8'h8e: sub = 8'h19; 8'h8f: sub = 8'h73;
         8'h90: sub = 8'h60; 8'h91: sub = 8'h81; 8'h92: sub = 8'h4f; 8'h93: sub = 8'hdc; 8'h94: sub = 8'h22; 8'h95: sub = 8'h2a; 8'h96: sub = 8'h90; 8'h97: sub = 8'h88;
         8'h98: sub = 8'h46; 8'h99: sub = 8'hee; 8'h9a: sub = 8'hb8; 8'h9b: sub = 8'h14; 8'h9c: sub = 8'hde; 8'h9d: sub = 8'h5e; 8'h9e: sub = 8'h0b; 8'h9f: sub = 8'hdb;
         8'ha0: sub = 8'he0; 8'ha1: sub = 8'h32; 8'ha2: sub = 8'h3a; 8'ha3: sub = 8'h0a; 8'ha4: sub = 8'h49; 8'ha5: sub = 8'h06; 8'ha6: sub = 8'h24; 8'ha7: sub = 8'h5c;
         8'ha8: sub = 8'hc2; 8'ha9: sub = 8'hd3; 8'haa: sub = 8'hac; 8'hab: sub = 8'h62; 8'hac: sub = 8'h91; 8'had: sub = 8'h95; 8'hae: sub = 8'he4; 8'haf: sub = 8'h79;
         8'hb0: sub = 8'he7; 8'hb1: sub = 8'hc8; 8'hb2: sub = 8'h37; 8'hb3: sub = 8'h6d; 8'hb4: sub = 8'h8d; 8'hb5: sub = 8'hd5; 8'hb6: sub = 8'h4e; 8'hb7: sub = 8'ha9;
         8'hb8: sub = 8'h6c; 8'hb9: sub = 8'h56; 8'hba: sub = 8'hf4; 8'hbb: sub = 8'hea; 8'hbc: sub = 8'h65; 8'hbd: sub = 8'h7a; 8'hbe: sub = 8'hae; 8'hbf: sub = 8'h08;
         8'hc0: sub = 8'hba; 8'hc1: sub = 8'h78; 8'hc2: sub = 8'h25; 8'hc3: sub = 8'h2e; 8'hc4: sub = 8'h1c; 8'hc5: sub = 8'ha6; 8'hc6: sub = 8'hb4; 8'hc7: sub = 8'hc6;
         8'hc8: sub = 8'he8; 8'hc9: sub = 8'hdd; 8'hca: sub = 8'h74; 8'hcb: sub = 8'h1f; 8'hcc: sub = 8'h4b; 8'hcd: sub = 8'hbd; 8'hce: sub = 8'h8b; 8'hcf: sub = 8'h8a;
         8'hd0: sub = 8'h70; 8'hd1: sub = 8'h3e; 8'hd2: sub = 8'hb5; 8'hd3: sub = 8'h66; 8'hd4: sub = 8'h48; 8'hd5: sub = 8'h03; 8'hd6: sub = 8'hf6; 8'hd7: sub = 8'h0e;
         8'hd8: sub = 8'h61; 8'hd9: sub = 8'h35; 8'hda: sub = 8'h57; 8'hdb: sub = 8'hb9; 8'hdc: sub = 8'h86; 8'hdd: sub = 8'hc1; 8'hde: sub = 8'h1d; 8'hdf: sub = 8'h9e;
         8'he0: sub = 8'he1; 8'he1: sub = 8'hf8; 8'he2: sub = 8'h98; 8'he3: sub = 8'h11; 8'he4: sub = 8'h69; 8'he5: sub = 8'hd9; 8'he6: sub = 8'h8e; 8'he7: sub = 8'h94;
         8'he8: sub = 8'h9b; 8'he9: sub = 8'h1e; 8'hea: sub = 8'h87; 8'heb: sub = 8'he9; 8'hec: sub = 8'hce; 8'hed: sub = 8'h55; 8'hee: sub = 8'h28; 8'hef: sub = 8'hdf;
         8'hf0: sub = 8'h8c; 8'hf1: sub = 8'ha1; 8'hf2: sub = 8'h89; 8'hf3: sub = 8'h0d; 8'hf4: sub = 8'hbf; 8'hf5: sub = 8'he6; 8'hf6: sub = 8'h42; 8'hf7: sub = 8'h68;
         8'hf8: sub = 8'h41; 8'hf9: sub = 8'h99; 8'hfa: sub = 8'h2d; 8'hfb: sub = 8'h0f; 8'hfc: sub = 8'hb0; 8'hfd: sub = 8'h54; 8'hfe: sub = 8'hbb; 8'hff: sub = 8'h16;
         default: sub = 8'h00;
      endcase
   end

endmodule

// File: rtl/aes_key_expand.sv
// On-the-fly AES-128 key schedule. Holds only the current round key and
// derives the next one combinationally, committing it on each advance.
//   clk, rst_n : clock (rising edge), async active-low reset
//   load       : capture key_in as the round-0 key (wins over advance)
//   key_in     : cipher key, w0 in [127:96]
//   advance    : step to the next round key (same strobe as round_counter)
//   round_key  : current round key, registered
//   round      : index of round_key, 0..NR
//   key_valid  : round_key holds a schedule entry
//   is_last    : round == NR while valid
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int NR    = AES_NR,
   parameter int KEY_W = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [KEY_W-1:0] key_in,
   input  logic             advance,
   output logic [KEY_W-1:0] round_key,
   output logic [3:0]       round,
   output logic             key_valid,
   output logic             is_last
);

   localparam logic [3:0] LAST = 4'(NR);

   logic [KEY_W-1:0] key_q;
   logic [7:0]       rcon_q;
   logic [3:0]       round_q;
   logic             valid_q;

   word32_t w0, w1, w2, w3;
   word32_t rot_w3, sub_w3, t;
   word32_t n0, n1, n2, n3;
   logic    step;

   assign w0 = key_q[127:96];
   assign w1 = key_q[95:64];
   assign w2 = key_q[63:32];
   assign w3 = key_q[31:0];

   // RotWord: left-rotate by one byte
   assign rot_w3 = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_subword
      aes_sbox u_sbox (
         .a   (rot_w3[i*8 +: 8]),
         .sub (sub_w3[i*8 +: 8])
      );
   end

   assign t  = sub_w3 ^ {rcon_q, 24'h0};
   // Each new word chains off the one just produced
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   // Advance only steps a live schedule that has not reached the last round
   assign step = advance && valid_q && (round_q < LAST) && !load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q   <= '0;
         rcon_q  <= RCON_INIT;
         round_q <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         key_q   <= key_in;
         rcon_q  <= RCON_INIT;
         round_q <= '0;
         valid_q <= 1'b1;
      end else if (step) begin
         key_q   <= {n0, n1, n2, n3};
         rcon_q  <= xtime(rcon_q);
         round_q <= round_q + 4'd1;
      end
   end

   assign round_key = key_q;
   assign round     = round_q;
   assign key_valid = valid_q;
   assign is_last   = valid_q && (round_q == LAST);

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: a word-level FIPS-197 key
// expansion model (S-box derived from the GF(2^8) inverse) is compared
// against the DUT every cycle, plus directed checks on known vectors.
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         load = 1'b0;
   logic         advance = 1'b0;
   logic [127:0] key_in = '0;
   logic [127:0] round_key;
   logic [3:0]   round;
   logic         key_valid;
   logic         is_last;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   aes_key_expand dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .key_in    (key_in),
      .advance   (advance),
      .round_key (round_key),
      .round     (round),
      .key_valid (key_valid),
      .is_last   (is_last)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0] sbox_t [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] b;
      inv = 8'h00;
      if (a != 8'h00) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, a);
      end
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      return b;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   // Full FIPS-197 expansion, returning round key r of cipher key k
   function automatic logic [127:0] expand(input logic [127:0] k, input int r);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   logic [127:0] m_key0;
   int           m_round;
   logic         m_valid;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_key0  <= '0;
         m_round <= 0;
         m_valid <= 1'b0;
      end else if (load) begin
         m_key0  <= key_in;
         m_round <= 0;
         m_valid <= 1'b1;
      end else if (advance && m_valid && m_round < 10) begin
         m_round <= m_round + 1;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   bit model_ready = 1'b0;

   always @(negedge clk) begin
      if (model_ready) begin
         chk("round_key", round_key, m_valid ? expand(m_key0, m_round) : 128'h0);
         chk("round", 128'(round), 128'(m_round));
         chk("key_valid", 128'(key_valid), 128'(m_valid));
         chk("is_last", 128'(is_last), 128'(m_valid && m_round == 10));
      end
   end

   task automatic step(input logic ld, input logic adv, input logic [127:0] k);
      @(posedge clk);
      #1;
      load    = ld;
      advance = adv;
      key_in  = k;
   endtask

   logic [127:0] k2;

   initial begin
      for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
      chk("model_sbox_00", 128'(sbox_t[8'h00]), 128'h63);
      chk("model_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
      chk("model_fips_r1", expand(FIPS_KEY, 1), FIPS_R1);
      chk("model_fips_r10", expand(FIPS_KEY, 10), FIPS_R10);
      model_ready = 1'b1;

      // 1: reset held while strobes toggle
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) step(i[0], ~i[0], FIPS_KEY);
      chk("reset_key", round_key, 128'h0);
      chk("reset_round", 128'(round), 128'h0);
      chk("reset_valid", 128'(key_valid), 128'h0);
      chk("reset_last", 128'(is_last), 128'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // 2: load FIPS key
      step(1, 0, FIPS_KEY);
      step(0, 0, '0);
      chk("load_key", round_key, FIPS_KEY);
      chk("load_round", 128'(round), 128'h0);
      chk("load_valid", 128'(key_valid), 128'h1);

      // 3: one advance
      step(0, 1, '0);
      step(0, 0, '0);
      chk("r1_key", round_key, FIPS_R1);
      chk("r1_round", 128'(round), 128'h1);

      // 4: ten back-to-back advances, then an 11th
      step(1, 0, FIPS_KEY);
      for (int i = 0; i < 10; i++) step(0, 1, '0);
      step(0, 0, '0);
      chk("r10_key", round_key, FIPS_R10);
      chk("r10_round", 128'(round), 128'd10);
      chk("r10_last", 128'(is_last), 128'h1);
      step(0, 1, '0);
      step(0, 0, '0);
      chk("r11_key", round_key, FIPS_R10);
      chk("r11_round", 128'(round), 128'd10);
      chk("r11_last", 128'(is_last), 128'h1);

      // 5: load and advance together at round 5
      k2 = {$urandom, $urandom, $urandom, $urandom};
      step(1, 0, FIPS_KEY);
      for (int i = 0; i < 5; i++) step(0, 1, '0);
      step(1, 1, k2);
      step(0, 0, '0);
      chk("ldadv_round", 128'(round), 128'h0);
      chk("ldadv_key", round_key, k2);

      // 6: async reset mid-cycle at round 4
      step(1, 0, FIPS_KEY);
      for (int i = 0; i < 4; i++) step(0, 1, '0);
      step(0, 0, '0);
      chk("pre_rst_round", 128'(round), 128'd4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_key", round_key, 128'h0);
      chk("async_round", 128'(round), 128'h0);
      chk("async_valid", 128'(key_valid), 128'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(0, 1, '0);
      step(0, 0, '0);
      chk("post_rst_valid", 128'(key_valid), 128'h0);
      chk("post_rst_round", 128'(round), 128'h0);

      // Randomized traffic with occasional async reset pulses
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
              {$urandom, $urandom, $urandom, $urandom});
         if ($urandom_range(0, 299) == 0) begin
            #2;
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
         end
      end
      step(0, 0, '0);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
